truth_table_sequencer: RTL and testbench

//   Sequences a 4-input, 1-output combinational function-under-test (FUT).
//   On start, drives all 16 input vectors {a,b,c,d} (a = MSB) in order 0..15.

---
 rtl/truth_table_sequencer.sv | 109 ++++++++++
 tb/tb_truth_table_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// Walks a 4-input combinational block through all 16 input vectors, captures its
// output into a truth table and grades the table against an expected minterm mask.
module truth_table_sequencer #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [15:0] EXPECTED = 16'hAC3C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        fut_s,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [15:0] mismatch,
    output logic [4:0]  err_count,
    output logic        pass
);
    // state | meaning
    // IDLE  | waiting for start; previous sweep's results held
    // RUN   | driving vectors 0..15, sampling fut_s after SETTLE hold cycles
    // FIN   | single cycle with done high, then back to IDLE

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t     state;
    logic [3:0] vector;
    logic [3:0] cnt;
    logic       miss;
    logic [4:0] err_next;

    assign {a, b, c, d} = vector;
    assign miss         = fut_s ^ EXPECTED[vector];
    // Includes the sample taken this cycle so the final pass flag sees vector 15.
    assign err_next     = err_count + {4'd0, miss};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            vector    <= 4'd0;
            cnt       <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            result    <= 16'd0;
            mismatch  <= 16'd0;
            err_count <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        vector    <= 4'd0;
                        cnt       <= 4'd0;
                        pass      <= 1'b0;
                        result    <= 16'd0;
                        mismatch  <= 16'd0;
                        err_count <= 5'd0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // Partial result/mismatch/err_count stay visible for debug.
                        state  <= IDLE;
                        busy   <= 1'b0;
                        pass   <= 1'b0;
                        vector <= 4'd0;
                        cnt    <= 4'd0;
                    end else if (cnt != SETTLE_CNT) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        result[vector]   <= fut_s;
                        mismatch[vector] <= miss;
                        err_count        <= err_next;
                        cnt              <= 4'd0;
                        if (vector == 4'd15) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == 5'd0);
                        end else begin
                            vector <= vector + 4'd1;
                        end
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    done   <= 1'b0;
                    vector <= 4'd0;
                    cnt    <= 4'd0;
                    if (abort) pass <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: a table of FUT truth tables, random FUTs checked
// against a population-count model, and hand sequences for reset, restart and abort.
module tb_truth_table_sequencer;
    localparam logic [15:0] EXP = 16'hAC3C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start1 = 1'b0, abort1 = 1'b0, start2 = 1'b0, abort2 = 1'b0;
    logic [15:0] tbl1 = EXP, tbl2 = EXP;
    logic        a1, b1, c1, d1, busy1, done1, pass1;
    logic        a2, b2, c2, d2, busy2, done2, pass2;
    logic [15:0] result1, mismatch1, result2, mismatch2;
    logic [4:0]  err1, err2;
    logic        fut_s1, fut_s2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign fut_s1 = tbl1[{a1, b1, c1, d1}];
    assign fut_s2 = tbl2[{a2, b2, c2, d2}];

    truth_table_sequencer #(.SETTLE(1), .EXPECTED(EXP)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1), .fut_s(fut_s1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .result(result1), .mismatch(mismatch1), .err_count(err1), .pass(pass1)
    );

    truth_table_sequencer #(.SETTLE(3), .EXPECTED(EXP)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2), .fut_s(fut_s2),
        .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2),
        .result(result2), .mismatch(mismatch2), .err_count(err2), .pass(pass2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) start2 = v; else start1 = v;
    endtask

    // One full sweep: checks vector stepping, busy, done latency/pulse count and final grading.
    task automatic do_sweep(input bit sel, input logic [15:0] tbl, input int restart_at,
                            input logic [15:0] exp_res, input logic [15:0] exp_mis,
                            input int exp_err, input bit exp_pass);
        int per, total, first, pulses;
        bit vec_bad, busy_bad;
        logic [3:0] vec;
        per = sel ? 4 : 2;
        total = 16 * per;
        first = -1; pulses = 0; vec_bad = 0; busy_bad = 0;
        if (sel) tbl2 = tbl; else tbl1 = tbl;
        @(negedge clk); set_start(sel, 1'b1);
        @(negedge clk); set_start(sel, 1'b0);
        for (int n = 1; n <= total + 6; n++) begin
            @(negedge clk);
            vec = sel ? {a2, b2, c2, d2} : {a1, b1, c1, d1};
            if ((sel ? done2 : done1) === 1'b1) begin
                pulses++;
                if (first < 0) first = n;
            end
            if (n < total) begin
                if (vec !== 4'(n / per)) vec_bad = 1;
                if ((sel ? busy2 : busy1) !== 1'b1) busy_bad = 1;
            end else if ((sel ? busy2 : busy1) !== 1'b0) begin
                busy_bad = 1;
            end
            set_start(sel, n == restart_at);
        end
        set_start(sel, 1'b0);
        check("done_latency", 32'(first), 32'(total));
        check("done_pulses", 32'(pulses), 32'd1);
        check("vector_steps", {31'd0, vec_bad}, 32'd0);
        check("busy_window", {31'd0, busy_bad}, 32'd0);
        check("result", {16'd0, sel ? result2 : result1}, {16'd0, exp_res});
        check("mismatch", {16'd0, sel ? mismatch2 : mismatch1}, {16'd0, exp_mis});
        check("err_count", {27'd0, sel ? err2 : err1}, 32'(exp_err));
        check("pass", {31'd0, sel ? pass2 : pass1}, {31'd0, exp_pass});
    endtask

    typedef struct {
        logic [15:0] tbl;
        logic [15:0] res;
        logic [15:0] mis;
        int          err;
        bit          pass;
    } vec_t;

    vec_t vt[6];

    initial begin
        int seen;
        logic [15:0] t, m;

        vt[0] = '{16'hAC3C, 16'hAC3C, 16'h0000, 0,  1'b1};
        vt[1] = '{16'h0000, 16'h0000, 16'hAC3C, 8,  1'b0};
        vt[2] = '{16'hFFFF, 16'hFFFF, 16'h53C3, 8,  1'b0};
        vt[3] = '{16'hAC3D, 16'hAC3D, 16'h0001, 1,  1'b0};
        vt[4] = '{16'h2C3C, 16'h2C3C, 16'h8000, 1,  1'b0};
        vt[5] = '{16'h53C3, 16'h53C3, 16'hFFFF, 16, 1'b0};

        // Reset state
        #12;
        check("rst_busy", {31'd0, busy1}, 32'd0);
        check("rst_done", {31'd0, done1}, 32'd0);
        check("rst_pass", {31'd0, pass1}, 32'd0);
        check("rst_result", {16'd0, result1}, 32'd0);
        check("rst_err", {27'd0, err1}, 32'd0);
        check("rst_vector", {28'd0, a1, b1, c1, d1}, 32'd0);
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 6; i++)
            do_sweep(1'b0, vt[i].tbl, 0, vt[i].res, vt[i].mis, vt[i].err, vt[i].pass);

        // Results hold after done
        repeat (5) @(negedge clk);
        check("hold_result", {16'd0, result1}, {16'd0, vt[5].res});
        check("hold_err", {27'd0, err1}, 32'd16);

        // Golden FUT with longer settle
        do_sweep(1'b1, EXP, 0, EXP, 16'h0000, 0, 1'b1);

        // Restart request mid-sweep at vector 4 must be ignored
        do_sweep(1'b0, EXP, 8, EXP, 16'h0000, 0, 1'b1);

        // Randomized FUTs against the population-count model
        for (int i = 0; i < 12; i++) begin
            t = 16'($urandom());
            m = t ^ EXP;
            do_sweep(1'b0, t, 0, t, m, $countones(m), m == 16'd0);
        end

        // Abort at vector 5
        tbl1 = 16'hFFFF;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_at_vec5", {28'd0, a1, b1, c1, d1}, 32'd5);
        abort1 = 1'b1;
        @(negedge clk); abort1 = 1'b0;
        check("abort_busy", {31'd0, busy1}, 32'd0);
        check("abort_vector", {28'd0, a1, b1, c1, d1}, 32'd0);
        check("abort_pass", {31'd0, pass1}, 32'd0);
        check("abort_result", {16'd0, result1}, {16'd0, tbl1 & 16'h001F});
        check("abort_mismatch", {16'd0, mismatch1}, {16'd0, (tbl1 ^ EXP) & 16'h001F});
        check("abort_err", {27'd0, err1}, 32'($countones((tbl1 ^ EXP) & 16'h001F)));
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done1 === 1'b1 || busy1 === 1'b1) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        // start together with abort in IDLE: stays idle, nothing cleared
        start1 = 1'b1; abort1 = 1'b1;
        @(negedge clk); start1 = 1'b0; abort1 = 1'b0;
        @(negedge clk);
        check("start_abort_idle", {31'd0, busy1}, 32'd0);
        check("start_abort_keep", {16'd0, result1}, {16'd0, tbl1 & 16'h001F});

        // Fresh start after abort clears and reruns
        do_sweep(1'b0, EXP, 0, EXP, 16'h0000, 0, 1'b1);

        // Async reset mid-sweep at vector 7
        tbl1 = EXP;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        seen = 0;
        for (int n = 0; n < 40 && seen == 0; n++) begin
            @(negedge clk);
            if ({a1, b1, c1, d1} == 4'd7) seen = 1;
        end
        check("reach_vec7", 32'(seen), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_busy", {31'd0, busy1}, 32'd0);
        check("async_rst_result", {16'd0, result1}, 32'd0);
        check("async_rst_mismatch", {16'd0, mismatch1}, 32'd0);
        check("async_rst_err", {27'd0, err1}, 32'd0);
        check("async_rst_vector", {28'd0, a1, b1, c1, d1}, 32'd0);
        check("async_rst_done_pass", {30'd0, done1, pass1}, 32'd0);
        @(negedge clk); reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {31'd0, busy1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
